// File: rtl/mc_control.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing over a shared req/ack memory port.
// Latency: outputs are combinational from state and inputs; 3 (branch), 4 (ALU/jump/store), 5 (load) cycles plus wait cycles.
// Backpressure: FETCH and MEM hold mem_req until mem_ack, trapping with bus_err after MEM_TIMEOUT unacked cycles.
module mc_control #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             brtaken,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord_sel,
    output logic             ir_wen,
    output logic             pc_wen,
    output logic             pc_sel,
    output logic             reg_wen,
    output logic             a_sel,
    output logic             b_sel,
    output logic [1:0]       wb_sel,
    output logic [2:0]       imm_sel,
    output logic [3:0]       alu_sel,
    output logic             retire,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MDR = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord_sel;
        logic       ir_wen;
        logic       pc_wen;
        logic       pc_sel;
        logic       reg_wen;
        logic       a_sel;
        logic       b_sel;
        logic [1:0] wb_sel;
        logic [2:0] imm_sel;
        logic [3:0] alu_sel;
        logic       retire;
    } ctrl_t;

    state_t            state;
    state_t            state_nxt;
    ctrl_t             ctrl;
    logic              illegal_set;
    logic              bus_err_set;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_expired;
    logic              opc_legal;
    logic              unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        opc_legal = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: opc_legal = 1'b1;
            default:                                opc_legal = 1'b0;
        endcase
    end

    // Last allowed request cycle: no ack now means the access is abandoned.
    assign wait_expired = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

    always_comb begin
        ctrl        = '0;
        state_nxt   = state;
        illegal_set = 1'b0;
        bus_err_set = 1'b0;
        case (state)
            S_INIT: state_nxt = S_FETCH;

            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                if (mem_ack) begin
                    ctrl.ir_wen = 1'b1;
                    ctrl.pc_wen = 1'b1;
                    state_nxt   = S_DECODE;
                end else if (wait_expired) begin
                    bus_err_set = 1'b1;
                    state_nxt   = S_TRAP;
                end
            end

            S_DECODE: begin
                if (opc_legal) begin
                    state_nxt = S_EXEC;
                end else begin
                    illegal_set = 1'b1;
                    state_nxt   = S_TRAP;
                end
            end

            S_EXEC: begin
                state_nxt = S_WB;
                case (opcode)
                    OPC_LUI: begin
                        ctrl.imm_sel = IMM_U;
                        ctrl.b_sel   = 1'b1;
                        ctrl.alu_sel = ALU_PASSB;
                    end
                    OPC_AUIPC: begin
                        ctrl.imm_sel = IMM_U;
                        ctrl.a_sel   = 1'b1;
                        ctrl.b_sel   = 1'b1;
                        ctrl.alu_sel = ALU_ADD;
                    end
                    OPC_JAL: begin
                        ctrl.imm_sel = IMM_J;
                        ctrl.a_sel   = 1'b1;
                        ctrl.b_sel   = 1'b1;
                        ctrl.alu_sel = ALU_ADD;
                    end
                    OPC_JALR: begin
                        ctrl.imm_sel = IMM_I;
                        ctrl.b_sel   = 1'b1;
                        ctrl.alu_sel = ALU_ADD;
                    end
                    // Branch target comes from OLDPC+imm, so PC is written straight from the ALU.
                    OPC_BRANCH: begin
                        ctrl.imm_sel = IMM_B;
                        ctrl.a_sel   = 1'b1;
                        ctrl.b_sel   = 1'b1;
                        ctrl.alu_sel = ALU_ADD;
                        ctrl.pc_wen  = brtaken;
                        ctrl.pc_sel  = 1'b1;
                        ctrl.retire  = 1'b1;
                        state_nxt    = S_FETCH;
                    end
                    OPC_LOAD: begin
                        ctrl.imm_sel = IMM_I;
                        ctrl.b_sel   = 1'b1;
                        ctrl.alu_sel = ALU_ADD;
                        state_nxt    = S_MEM;
                    end
                    OPC_STORE: begin
                        ctrl.imm_sel = IMM_S;
                        ctrl.b_sel   = 1'b1;
                        ctrl.alu_sel = ALU_ADD;
                        state_nxt    = S_MEM;
                    end
                    // Only the shift-right pair uses funct7[5] among immediate ops (SRLI vs SRAI).
                    OPC_OPIMM: begin
                        ctrl.imm_sel = IMM_I;
                        ctrl.b_sel   = 1'b1;
                        ctrl.alu_sel = (funct3 == 3'b101) ? {funct7[5], funct3} : {1'b0, funct3};
                    end
                    OPC_OP: begin
                        ctrl.alu_sel = {funct7[5], funct3};
                    end
                    default: state_nxt = S_WB;
                endcase
            end

            S_MEM: begin
                ctrl.mem_req  = 1'b1;
                ctrl.iord_sel = 1'b1;
                ctrl.mem_we   = (opcode == OPC_STORE);
                if (mem_ack) begin
                    if (opcode == OPC_STORE) begin
                        ctrl.retire = 1'b1;
                        state_nxt   = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end else if (wait_expired) begin
                    bus_err_set = 1'b1;
                    state_nxt   = S_TRAP;
                end
            end

            S_WB: begin
                ctrl.reg_wen = 1'b1;
                ctrl.retire  = 1'b1;
                state_nxt    = S_FETCH;
                case (opcode)
                    OPC_LOAD: ctrl.wb_sel = WB_MDR;
                    OPC_JAL, OPC_JALR: begin
                        ctrl.wb_sel = WB_PC;
                        ctrl.pc_wen = 1'b1;
                        ctrl.pc_sel = 1'b1;
                    end
                    default: ctrl.wb_sel = WB_ALU;
                endcase
            end

            S_TRAP: state_nxt = S_TRAP;

            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_INIT;
            wait_cnt    <= '0;
            illegal     <= 1'b0;
            bus_err     <= 1'b0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            state     <= state_nxt;
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (ctrl.retire) begin
                instret_cnt <= instret_cnt + CNT_W'(1);
            end
            // Any state change restarts the wait count, which covers entry to FETCH and MEM.
            if (state_nxt != state) begin
                wait_cnt <= '0;
            end else if (ctrl.mem_req && !mem_ack) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (illegal_set) begin
                illegal <= 1'b1;
            end
            if (bus_err_set) begin
                bus_err <= 1'b1;
            end
        end
    end

    assign mem_req  = ctrl.mem_req;
    assign mem_we   = ctrl.mem_we;
    assign iord_sel = ctrl.iord_sel;
    assign ir_wen   = ctrl.ir_wen;
    assign pc_wen   = ctrl.pc_wen;
    assign pc_sel   = ctrl.pc_sel;
    assign reg_wen  = ctrl.reg_wen;
    assign a_sel    = ctrl.a_sel;
    assign b_sel    = ctrl.b_sel;
    assign wb_sel   = ctrl.wb_sel;
    assign imm_sel  = ctrl.imm_sel;
    assign alu_sel  = ctrl.alu_sel;
    assign retire   = ctrl.retire;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: instruction sequences with hand-computed control vectors and counters.
// Built with MEM_TIMEOUT=4 and CNT_W=8 so timeout and counter wrap are reachable quickly.
module tb_mc_control;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [6:0]       opcode = '0;
    logic [2:0]       funct3 = '0;
    logic [6:0]       funct7 = '0;
    logic             brtaken = 1'b0;
    logic             mem_ack = 1'b0;
    logic             mem_req, mem_we, iord_sel, ir_wen, pc_wen, pc_sel, reg_wen, a_sel, b_sel;
    logic [1:0]       wb_sel;
    logic [2:0]       imm_sel;
    logic [3:0]       alu_sel;
    logic             retire, illegal, bus_err;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;
    logic [18:0]      ctl;

    int n_cmp = 0;
    int n_err = 0;

    mc_control #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .brtaken(brtaken), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .iord_sel(iord_sel), .ir_wen(ir_wen), .pc_wen(pc_wen), .pc_sel(pc_sel),
        .reg_wen(reg_wen), .a_sel(a_sel), .b_sel(b_sel), .wb_sel(wb_sel),
        .imm_sel(imm_sel), .alu_sel(alu_sel), .retire(retire), .illegal(illegal),
        .bus_err(bus_err), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    assign ctl = {mem_req, mem_we, iord_sel, ir_wen, pc_wen, pc_sel, reg_wen, a_sel, b_sel,
                  wb_sel, imm_sel, alu_sel, retire};

    function automatic logic [18:0] cv(input logic req, we, io, irw, pcw, pcs, rw, as, bs,
                                       input logic [1:0] wb, input logic [2:0] imm,
                                       input logic [3:0] alu, input logic ret);
        return {req, we, io, irw, pcw, pcs, rw, as, bs, wb, imm, alu, ret};
    endfunction

    localparam logic [18:0] C_ZERO  = '0;
    localparam logic [18:0] C_FWAIT = 19'h40000;
    localparam logic [18:0] C_FACK  = 19'h4C000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs now, compare the control vector mid-cycle, advance past the edge.
    task automatic cyc(input string tag, input logic ack, input logic br, input logic [18:0] exp);
        mem_ack = ack;
        brtaken = br;
        @(negedge clk);
        chk(tag, 32'(ctl), 32'(exp));
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        brtaken = 1'b0;
    endtask

    task automatic set_ir(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
        opcode = opc;
        funct3 = f3;
        funct7 = f7;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ctl", 32'(ctl), 32'(C_ZERO));
        chk("rst_flags", {30'd0, illegal, bus_err}, 32'd0);
        chk("rst_cnts", {16'd0, cycle_cnt, instret_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("init", 1'b0, 1'b0, C_ZERO);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // ADDI x1,x0,5
        set_ir(7'b0010011, 3'b000, 7'b0000000);
        cyc("addi_fetch", 1'b1, 1'b0, C_FACK);
        cyc("addi_dec_ack_ignored", 1'b1, 1'b0, C_ZERO);
        cyc("addi_exec", 1'b0, 1'b0, cv(0,0,0,0,0,0,0,0,1, 2'd0, 3'd0, 4'b0000, 0));
        chk("addi_instret_before", 32'(instret_cnt), 32'd0);
        cyc("addi_wb", 1'b0, 1'b0, cv(0,0,0,0,0,0,1,0,0, 2'd0, 3'd0, 4'b0000, 1));
        chk("addi_instret", 32'(instret_cnt), 32'd1);
        chk("addi_cycles", 32'(cycle_cnt), 32'd5);

        // LW with three wait cycles in MEM
        set_ir(7'b0000011, 3'b010, 7'b0000000);
        cyc("lw_fetch", 1'b1, 1'b0, C_FACK);
        cyc("lw_dec", 1'b0, 1'b0, C_ZERO);
        cyc("lw_exec", 1'b0, 1'b0, cv(0,0,0,0,0,0,0,0,1, 2'd0, 3'd0, 4'b0000, 0));
        for (int i = 0; i < 3; i++) begin
            cyc("lw_mem_wait", 1'b0, 1'b0, cv(1,0,1,0,0,0,0,0,0, 2'd0, 3'd0, 4'b0000, 0));
        end
        cyc("lw_mem_ack", 1'b1, 1'b0, cv(1,0,1,0,0,0,0,0,0, 2'd0, 3'd0, 4'b0000, 0));
        cyc("lw_wb", 1'b0, 1'b0, cv(0,0,0,0,0,0,1,0,0, 2'd1, 3'd0, 4'b0000, 1));
        chk("lw_cycles", 32'(cycle_cnt), 32'd13);
        chk("lw_instret", 32'(instret_cnt), 32'd2);

        // BEQ taken, then not taken
        set_ir(7'b1100011, 3'b000, 7'b0000000);
        cyc("beq_t_fetch", 1'b1, 1'b0, C_FACK);
        cyc("beq_t_dec", 1'b0, 1'b0, C_ZERO);
        cyc("beq_t_exec", 1'b0, 1'b1, cv(0,0,0,0,1,1,0,1,1, 2'd0, 3'd2, 4'b0000, 1));
        cyc("beq_nt_fetch", 1'b1, 1'b0, C_FACK);
        cyc("beq_nt_dec", 1'b0, 1'b0, C_ZERO);
        cyc("beq_nt_exec", 1'b0, 1'b0, cv(0,0,0,0,0,1,0,1,1, 2'd0, 3'd2, 4'b0000, 1));
        chk("beq_cycles", 32'(cycle_cnt), 32'd19);
        chk("beq_instret", 32'(instret_cnt), 32'd4);

        // SRAI, SRLI, SUB
        set_ir(7'b0010011, 3'b101, 7'b0100000);
        cyc("srai_fetch", 1'b1, 1'b0, C_FACK);
        cyc("srai_dec", 1'b0, 1'b0, C_ZERO);
        cyc("srai_exec", 1'b0, 1'b0, cv(0,0,0,0,0,0,0,0,1, 2'd0, 3'd0, 4'b1101, 0));
        cyc("srai_wb", 1'b0, 1'b0, cv(0,0,0,0,0,0,1,0,0, 2'd0, 3'd0, 4'b0000, 1));
        set_ir(7'b0010011, 3'b101, 7'b0000000);
        cyc("srli_fetch", 1'b1, 1'b0, C_FACK);
        cyc("srli_dec", 1'b0, 1'b0, C_ZERO);
        cyc("srli_exec", 1'b0, 1'b0, cv(0,0,0,0,0,0,0,0,1, 2'd0, 3'd0, 4'b0101, 0));
        cyc("srli_wb", 1'b0, 1'b0, cv(0,0,0,0,0,0,1,0,0, 2'd0, 3'd0, 4'b0000, 1));
        set_ir(7'b0110011, 3'b000, 7'b0100000);
        cyc("sub_fetch", 1'b1, 1'b0, C_FACK);
        cyc("sub_dec", 1'b0, 1'b0, C_ZERO);
        cyc("sub_exec", 1'b0, 1'b0, cv(0,0,0,0,0,0,0,0,0, 2'd0, 3'd0, 4'b1000, 0));
        cyc("sub_wb", 1'b0, 1'b0, cv(0,0,0,0,0,0,1,0,0, 2'd0, 3'd0, 4'b0000, 1));

        // SW, zero-wait store retires in MEM
        set_ir(7'b0100011, 3'b010, 7'b0000000);
        cyc("sw_fetch", 1'b1, 1'b0, C_FACK);
        cyc("sw_dec", 1'b0, 1'b0, C_ZERO);
        cyc("sw_exec", 1'b0, 1'b0, cv(0,0,0,0,0,0,0,0,1, 2'd0, 3'd1, 4'b0000, 0));
        cyc("sw_mem", 1'b1, 1'b0, cv(1,1,1,0,0,0,0,0,0, 2'd0, 3'd0, 4'b0000, 1));

        // JAL
        set_ir(7'b1101111, 3'b000, 7'b0000000);
        cyc("jal_fetch", 1'b1, 1'b0, C_FACK);
        cyc("jal_dec", 1'b0, 1'b0, C_ZERO);
        cyc("jal_exec", 1'b0, 1'b0, cv(0,0,0,0,0,0,0,1,1, 2'd0, 3'd4, 4'b0000, 0));
        cyc("jal_wb", 1'b0, 1'b0, cv(0,0,0,0,1,1,1,0,0, 2'd2, 3'd0, 4'b0000, 1));
        chk("mix_cycles", 32'(cycle_cnt), 32'd39);
        chk("mix_instret", 32'(instret_cnt), 32'd9);

        // Illegal opcode traps, never retires, cycle counter keeps running and wraps
        set_ir(7'b1111111, 3'b000, 7'b0000000);
        cyc("ill_fetch", 1'b1, 1'b0, C_FACK);
        cyc("ill_dec", 1'b0, 1'b0, C_ZERO);
        cyc("ill_trap", 1'b1, 1'b0, C_ZERO);
        chk("ill_flag", {30'd0, illegal, bus_err}, 32'd2);
        chk("ill_instret", 32'(instret_cnt), 32'd9);
        chk("ill_cycles", 32'(cycle_cnt), 32'd42);
        for (int i = 0; i < 300 && cycle_cnt != 8'hFF; i++) begin
            @(posedge clk);
            #1;
        end
        chk("cyc_at_max", 32'(cycle_cnt), 32'hFF);
        @(posedge clk);
        #1;
        chk("cyc_wrap", 32'(cycle_cnt), 32'd0);
        chk("trap_hold", {30'd0, illegal, bus_err}, 32'd2);
        do_reset();

        // Fetch timeout: four unacked request cycles, then TRAP with bus_err
        for (int i = 0; i < 4; i++) begin
            cyc("to_fetch_wait", 1'b0, 1'b0, C_FWAIT);
        end
        cyc("to_trap", 1'b1, 1'b0, C_ZERO);
        chk("to_flags", {30'd0, illegal, bus_err}, 32'd1);
        do_reset();

        // Ack in the last allowed cycle is accepted
        set_ir(7'b0010011, 3'b000, 7'b0000000);
        for (int i = 0; i < 3; i++) begin
            cyc("late_fetch_wait", 1'b0, 1'b0, C_FWAIT);
        end
        cyc("late_fetch_ack", 1'b1, 1'b0, C_FACK);
        cyc("late_dec", 1'b0, 1'b0, C_ZERO);
        cyc("late_exec", 1'b0, 1'b0, cv(0,0,0,0,0,0,0,0,1, 2'd0, 3'd0, 4'b0000, 0));
        chk("late_flags", {30'd0, illegal, bus_err}, 32'd0);
        do_reset();

        // Reset asserted during a MEM wait drops mem_req at once
        set_ir(7'b0000011, 3'b010, 7'b0000000);
        cyc("rm_fetch", 1'b1, 1'b0, C_FACK);
        cyc("rm_dec", 1'b0, 1'b0, C_ZERO);
        cyc("rm_exec", 1'b0, 1'b0, cv(0,0,0,0,0,0,0,0,1, 2'd0, 3'd0, 4'b0000, 0));
        cyc("rm_mem_wait", 1'b0, 1'b0, cv(1,0,1,0,0,0,0,0,0, 2'd0, 3'd0, 4'b0000, 0));
        cyc("rm_mem_wait", 1'b0, 1'b0, cv(1,0,1,0,0,0,0,0,0, 2'd0, 3'd0, 4'b0000, 0));
        do_reset();
        cyc("rm_refetch", 1'b0, 1'b0, C_FWAIT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control unit for the RV32I core. It is the parametrised successor of the single-cycle decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, drives a shared instruction/data memory port with a req/ack handshake, and bounds each memory wait with a timeout. It also fixes SRAI/SRLI ALU decoding, traps on illegal opcodes, and keeps cycle and retired-instruction counters.

## Interface
- CNT_W, 32, width of cycle_cnt and instret_cnt (wrap-around).
- MEM_TIMEOUT, 16, max cycles mem_req stays high without mem_ack; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset asynchronous and active-low
- opcode  in  7  IR[6:0]; valid from DECODE onward
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- brtaken  in  1  branch comparator result; valid in EXEC
- mem_ack  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  1 = write (M_WRITE), 0 = read
- iord_sel  out  1  address source: 0 = PC, 1 = ALU-out register
- ir_wen  out  1  load IR and OLDPC (PC of the fetched instruction)
- pc_wen  out  1  PC write enable
- pc_sel  out  1  0 = PC+4, 1 = ALU-out register
- reg_wen  out  1  register-file write
- a_sel  out  1  0 = rs1, 1 = OLDPC
- b_sel  out  1  0 = rs2, 1 = immediate
- wb_sel  out  2  0 = ALU-out, 1 = memory data register, 2 = PC (already PC+4)
- imm_sel  out  3  I=0, S=1, B=2, U=3, J=4
- alu_sel  out  4  {funct7[5], funct3} codes; ADD=4'b0000, PASSB=4'b1111
- retire  out  1  one-cycle pulse in the final state of each instruction
- illegal  out  1  sticky illegal-opcode trap
- bus_err  out  1  sticky memory-timeout trap
- cycle_cnt  out  CNT_W  cycles since reset
- instret_cnt  out  CNT_W  retired instructions

## Operation
- States: INIT, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Every output not listed for a state is 0, including all don't-cares.
- INIT: one cycle after reset release, all outputs 0, then FETCH.
- FETCH: mem_req=1, mem_we=0, iord_sel=0.
  - On mem_ack: ir_wen=1, pc_wen=1, pc_sel=0 in that cycle; next state DECODE.
  - Without mem_ack: stay in FETCH.
- DECODE: legal opcodes (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP) go to EXEC; any other opcode goes to TRAP with illegal=1.
- EXEC: imm_sel, a_sel, b_sel and alu_sel follow the single-cycle mapping:
  - LUI: PASSB.
  - AUIPC, JAL, BRANCH: A=OLDPC, ADD.
  - JALR, LOAD, STORE: A=rs1, ADD.
  - OP: B=rs2.
  - Next state: LOAD/STORE go to MEM; BRANCH goes to FETCH with retire=1, and pc_wen=brtaken, pc_sel=1 (target is computed in EXEC from OLDPC, so the datapath writes the ALU result directly); all others go to WB.
- alu_sel:
  - OP: {funct7[5], funct3}.
  - OP-IMM: {funct7[5], funct3} when funct3=3'b101, else {1'b0, funct3}. This is the new behaviour: SRAI decodes as 4'b1101.
- MEM: mem_req=1, iord_sel=1, mem_we=1 for STORE.
  - On mem_ack: LOAD goes to WB; STORE goes to FETCH with retire=1.
- WB: reg_wen=1, retire=1, next state FETCH. wb_sel:
  - LOAD: 1.
  - JAL/JALR: 2, with pc_wen=1, pc_sel=1 in the same cycle.
  - Others: 0.
- TRAP: all control outputs 0; illegal/bus_err hold; cycle_cnt keeps counting; the FSM leaves TRAP only by reset.
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments each cycle that mem_req=1 and mem_ack=0.
  - If MEM_TIMEOUT≠0 and the counter equals MEM_TIMEOUT-1 with mem_ack=0, the next state is TRAP and bus_err sets.
  - mem_req is therefore high for at most MEM_TIMEOUT cycles per access.
  - An ack arriving in the last allowed cycle is accepted normally.
- Counters: cycle_cnt increments every cycle after reset release. instret_cnt increments on retire. Both wrap from 2^CNT_W-1 to 0.

## Timing
- Reset (async assert, applies immediately): state=INIT; all outputs 0; counters 0; illegal=bus_err=0.
- Reset asserted mid-access drops mem_req combinationally, with no completion cycle.
- Outputs decode combinationally from state, opcode, funct3, funct7, brtaken and mem_ack. ir_wen, the fetch pc_wen, and the state transitions fire in the cycle mem_ack is high.
- Zero-wait-state latencies (ack in the first request cycle), from FETCH entry:
  - BRANCH: 3 cycles.
  - ALU, LUI, AUIPC, JAL, JALR, STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- mem_ack while mem_req=0 is ignored.
- retire and a TRAP entry are never simultaneous; an illegal instruction does not retire.

## Test plan
- ADDI x1,x0,5 with ack in the first request cycle -> states FETCH, DECODE, EXEC, WB; alu_sel=0000, b_sel=1, reg_wen=1 in WB only; instret_cnt 0→1 after cycle 4.
- LW with 3 wait cycles in MEM -> mem_req high 4 cycles with iord_sel=1; WB with wb_sel=1; total 8 cycles.
- BEQ with brtaken=1, then brtaken=0 -> EXEC has pc_wen=1/pc_sel=1, then pc_wen=0; both return to FETCH and retire.
- SRAI (funct3=101, funct7=0100000) -> alu_sel=1101; SRLI -> 0101; OP SUB -> 1000.
- opcode 7'b1111111 -> TRAP after DECODE, illegal=1; no retire; cycle_cnt still increments; rst_n low clears everything.
- MEM_TIMEOUT=4, no ack in FETCH -> mem_req high exactly 4 cycles, then bus_err=1. Second run with ack on cycle 4 -> normal DECODE. Third run with rst_n low during the MEM wait -> mem_req drops at once and INIT follows release.
